// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state encoding and GF(2^8) helpers for the key schedule.
package aes_pkg;

  localparam int NB_BYTE     = 8;
  localparam int NB_WORD     = 32;
  localparam int NB_KEY      = 128;
  localparam int N_ROUNDS    = 10;
  localparam int N_SBOX      = NB_WORD / NB_BYTE;
  localparam int N_KEY_WORDS = NB_KEY / NB_WORD;

  localparam logic [NB_BYTE-1:0] AES_POLY = 8'h1B;
  localparam logic [NB_BYTE-1:0] AFFINE_C = 8'h63;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SUB_WAIT,
    ST_UPDATE
  } state_t;

  // Multiply by x modulo x^8+x^4+x^3+x+1; also drives the rcon sequence.
  function automatic logic [NB_BYTE-1:0] rcon_next(input logic [NB_BYTE-1:0] a);
    return {a[NB_BYTE-2:0], 1'b0} ^ (a[NB_BYTE-1] ? AES_POLY : 8'h00);
  endfunction

  function automatic logic [NB_BYTE-1:0] gf_mul(input logic [NB_BYTE-1:0] a,
                                                input logic [NB_BYTE-1:0] b);
    logic [NB_BYTE-1:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < NB_BYTE; i++) begin
      if (b[i]) p = p ^ x;
      x = rcon_next(x);
    end
    return p;
  endfunction

  // a^254 = a^-1 for a != 0; naturally maps 0 to 0.
  function automatic logic [NB_BYTE-1:0] gf_inv(input logic [NB_BYTE-1:0] a);
    logic [NB_BYTE-1:0] sq, acc;
    sq  = a;
    acc = 8'h01;
    for (int k = 1; k < NB_BYTE; k++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [NB_BYTE-1:0] sbox_affine(input logic [NB_BYTE-1:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ AFFINE_C;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES byte S-box: free-running GF(2^8) inversion pipeline followed by the affine map.
// Latency is 2 + SBOX_OUT_REG cycles from i_byte to o_byte.
module aes_sbox
  import aes_pkg::*;
#(
  parameter int SBOX_OUT_REG = 0
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NB_BYTE-1:0] i_byte,
  output logic [NB_BYTE-1:0] o_byte
);

  logic [NB_BYTE-1:0] r_in;
  logic [NB_BYTE-1:0] r_inv;
  logic [NB_BYTE-1:0] w_last;

  // Input capture then registered inverse; the pipeline never stalls.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_in  <= '0;
      r_inv <= '0;
    end else begin
      r_in  <= i_byte;
      r_inv <= gf_inv(r_in);
    end
  end

  if (SBOX_OUT_REG != 0) begin : g_oreg
    logic [NB_BYTE-1:0] r_out;
    // Extra stage to shorten the path into the affine transform and key XORs.
    always_ff @(posedge i_clock) begin
      if (i_reset) r_out <= '0;
      else         r_out <= r_inv;
    end
    assign w_last = r_out;
  end else begin : g_noreg
    assign w_last = r_inv;
  end

  assign o_byte = sbox_affine(w_last);

endmodule

// File: rtl/aes128_key_expansion.sv
// Sequential AES-128 key schedule: emits round keys 0..10 one at a time.
// Optional macro AES_KEY_EXP_RESTART_EN: i_start while busy aborts and reloads.
module aes128_key_expansion
  import aes_pkg::*;
#(
  parameter int NB_BYTE      = 8,
  parameter int NB_KEY       = 128,
  parameter int SBOX_OUT_REG = 0
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic [NB_KEY-1:0] i_key,
  input  logic              i_start,
  output logic              o_busy,
  output logic [NB_KEY-1:0] o_round_key,
  output logic              o_round_key_valid,
  output logic [3:0]        o_round_idx,
  output logic              o_done
);

  localparam int SBOX_LAT = 2 + SBOX_OUT_REG;

  state_t                               r_state, w_state_nxt;
  logic                                 w_accept;
  logic [NB_KEY-1:0]                    r_key;
  logic [NB_BYTE-1:0]                   r_rcon;
  logic [3:0]                           r_round;
  logic [1:0]                           r_wait;

  logic [N_KEY_WORDS-1:0][NB_WORD-1:0]  w_words, w_words_nxt;
  logic [N_SBOX-1:0][NB_BYTE-1:0]       w_sb_in, w_sb_out;
  logic [NB_WORD-1:0]                   w_t;

  // Word N_KEY_WORDS-1 is w0 (key MSBs), word 0 is w3.
  assign w_words = r_key;
  assign w_sb_in = {w_words[0][NB_WORD-NB_BYTE-1:0], w_words[0][NB_WORD-1 -: NB_BYTE]};
  assign w_t     = w_sb_out ^ {r_rcon, {(NB_WORD-NB_BYTE){1'b0}}};

  for (genvar g = 0; g < N_SBOX; g++) begin : g_sbox
    aes_sbox #(.SBOX_OUT_REG(SBOX_OUT_REG)) u_sbox (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_byte  (w_sb_in[g]),
      .o_byte  (w_sb_out[g])
    );
  end

  // Chained XOR: each new word folds in the previous new word.
  always_comb begin
    logic [NB_WORD-1:0] w_acc;
    w_acc       = w_t;
    w_words_nxt = '0;
    for (int i = N_KEY_WORDS-1; i >= 0; i--) begin
      w_acc          = w_acc ^ w_words[i];
      w_words_nxt[i] = w_acc;
    end
  end

  // State register.
  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic and start acceptance.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE:     if (i_start) begin
                     w_accept    = 1'b1;
                     w_state_nxt = ST_LOAD;
                   end
      ST_LOAD:     w_state_nxt = ST_SUB_WAIT;
      ST_SUB_WAIT: if (r_wait == 2'(SBOX_LAT-1)) w_state_nxt = ST_UPDATE;
      ST_UPDATE:   w_state_nxt = (r_round == 4'(N_ROUNDS-1)) ? ST_IDLE : ST_SUB_WAIT;
      default:     w_state_nxt = ST_IDLE;
    endcase
`ifdef AES_KEY_EXP_RESTART_EN
    if (i_start && (r_state != ST_IDLE)) begin
      w_accept    = 1'b1;
      w_state_nxt = ST_LOAD;
    end
`endif
  end

  // Key/rcon/counter datapath and registered outputs.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_key             <= '0;
      r_rcon            <= 8'h01;
      r_round           <= '0;
      r_wait            <= '0;
      o_busy            <= 1'b0;
      o_round_key       <= '0;
      o_round_key_valid <= 1'b0;
      o_round_idx       <= '0;
      o_done            <= 1'b0;
    end else begin
      o_round_key_valid <= 1'b0;
      o_done            <= 1'b0;
      if (r_state == ST_IDLE) o_busy <= 1'b0;
      if (w_accept) begin
        r_key   <= i_key;
        r_rcon  <= 8'h01;
        r_round <= '0;
        r_wait  <= '0;
      end else begin
        case (r_state)
          ST_LOAD: begin
            o_busy            <= 1'b1;
            o_round_key       <= r_key;
            o_round_key_valid <= 1'b1;
            o_round_idx       <= '0;
            r_wait            <= '0;
          end
          ST_SUB_WAIT: r_wait <= r_wait + 2'd1;
          ST_UPDATE: begin
            r_key             <= w_words_nxt;
            o_round_key       <= w_words_nxt;
            o_round_key_valid <= 1'b1;
            o_round_idx       <= r_round + 4'd1;
            o_done            <= (r_round == 4'(N_ROUNDS-1));
            r_round           <= r_round + 4'd1;
            r_rcon            <= rcon_next(r_rcon);
            r_wait            <= '0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aes128_key_expansion.sv
// Bench for aes128_key_expansion: DUT0 default latency, DUT1 with SBOX_OUT_REG=1.
module tb_aes128_key_expansion;

  typedef struct packed {
    logic [127:0]       key;
    logic [10:0][127:0] rk;
  } vec_t;

  typedef struct {
    logic [127:0] key;
    int           idx;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] key   [2];
  logic         start [2];
  logic         busy  [2];
  logic [127:0] rk    [2];
  logic         vld   [2];
  logic [3:0]   idx   [2];
  logic         done  [2];

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   ndone [2];
  logic prev_vld [2];
  vec_t tbl [2];
  exp_t q [2][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes128_key_expansion #(.NB_BYTE(8), .NB_KEY(128), .SBOX_OUT_REG(0)) u_dut0 (
    .i_clock(clk), .i_reset(rst), .i_key(key[0]), .i_start(start[0]),
    .o_busy(busy[0]), .o_round_key(rk[0]), .o_round_key_valid(vld[0]),
    .o_round_idx(idx[0]), .o_done(done[0]));

  aes128_key_expansion #(.NB_BYTE(8), .NB_KEY(128), .SBOX_OUT_REG(1)) u_dut1 (
    .i_clock(clk), .i_reset(rst), .i_key(key[1]), .i_start(start[1]),
    .o_busy(busy[1]), .o_round_key(rk[1]), .o_round_key_valid(vld[1]),
    .o_round_idx(idx[1]), .o_done(done[1]));

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Called at a negedge; returns the cycle stamp just after the accepting edge.
  task automatic kick(input int d, input logic [127:0] k, output int tc);
    key[d]   = k;
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    tc = cyc;
  endtask

  task automatic push_run(input int d, input int v, input int tc, input int lat);
    for (int r = 0; r <= 10; r++) begin
      exp_t e;
      e.key = tbl[v].rk[r];
      e.idx = r;
      e.cyc = tc + 1 + r * (lat + 1);
      q[d].push_back(e);
    end
  endtask

  // Scoreboard: every valid pops one expected key and checks value, index, timing, done.
  always @(negedge clk) begin : mon
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (vld[d]) begin
        chk($sformatf("dut%0d adjacent_valid", d), prev_vld[d], 0);
        if (q[d].size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL dut%0d unexpected_valid: got idx %0d key %h at cycle %0d, none expected",
                   d, idx[d], rk[d], cyc);
        end else begin
          e = q[d].pop_front();
          chk($sformatf("dut%0d round%0d key", d, e.idx), rk[d], e.key);
          chk($sformatf("dut%0d round%0d idx", d, e.idx), idx[d], e.idx);
          chk($sformatf("dut%0d round%0d cycle", d, e.idx), cyc, e.cyc);
          chk($sformatf("dut%0d round%0d done", d, e.idx), done[d], e.idx == 10);
        end
        if (done[d]) ndone[d]++;
      end else if (done[d]) begin
        chk($sformatf("dut%0d done_without_valid", d), done[d], 0);
      end
      prev_vld[d] = vld[d];
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int tc, tc2, nd;
    tbl[0].key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    tbl[0].rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    tbl[0].rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    tbl[0].rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    tbl[0].rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    tbl[0].rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    tbl[0].rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    tbl[0].rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    tbl[0].rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    tbl[0].rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    tbl[0].rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    tbl[0].rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    tbl[1].key = 128'h0;
    tbl[1].rk[0]  = 128'h00000000000000000000000000000000;
    tbl[1].rk[1]  = 128'h62636363626363636263636362636363;
    tbl[1].rk[2]  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
    tbl[1].rk[3]  = 128'h90973450696ccffaf2f457330b0fac99;
    tbl[1].rk[4]  = 128'hee06da7b876a1581759e42b27e91ee2b;
    tbl[1].rk[5]  = 128'h7f2e2b88f8443e098dda7cbbf34b9290;
    tbl[1].rk[6]  = 128'hec614b851425758c99ff09376ab49ba7;
    tbl[1].rk[7]  = 128'h217517873550620bacaf6b3cc61bf09b;
    tbl[1].rk[8]  = 128'h0ef903333ba9613897060a04511dfa9f;
    tbl[1].rk[9]  = 128'hb1d4d8e28a7db9da1d7bb3de4c664941;
    tbl[1].rk[10] = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    ndone[0] = 0; ndone[1] = 0;
    prev_vld[0] = 1'b0; prev_vld[1] = 1'b0;
    rst = 1'b1;
    key[0] = '0; key[1] = '0; start[0] = 1'b0; start[1] = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset dut%0d busy", d), busy[d], 0);
      chk($sformatf("reset dut%0d key", d), rk[d], 0);
      chk($sformatf("reset dut%0d valid", d), vld[d], 0);
      chk($sformatf("reset dut%0d idx", d), idx[d], 0);
      chk($sformatf("reset dut%0d done", d), done[d], 0);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Table vectors on the default-latency DUT, with busy/hold timing probes.
    for (int v = 0; v < 2; v++) begin
      kick(0, tbl[v].key, tc);
      push_run(0, v, tc, 2);
      chk($sformatf("vec%0d busy_in_load", v), busy[0], 0);
      wait_cyc(tc + 1);
      chk($sformatf("vec%0d busy_round0", v), busy[0], 1);
      wait_cyc(tc + 4);
      chk($sformatf("vec%0d round1_at_T+4", v), rk[0], tbl[v].rk[1]);
      wait_cyc(tc + 31);
      chk($sformatf("vec%0d busy_round10", v), busy[0], 1);
      chk($sformatf("vec%0d done_at_T+31", v), done[0], 1);
      wait_cyc(tc + 32);
      chk($sformatf("vec%0d busy_after", v), busy[0], 0);
      chk($sformatf("vec%0d key_held", v), rk[0], tbl[v].rk[10]);
      chk($sformatf("vec%0d drained", v), q[0].size(), 0);
      repeat (2) @(negedge clk);
    end

    // Reset while round 5 is on the outputs, then a clean rerun.
    kick(0, tbl[0].key, tc);
    push_run(0, 0, tc, 2);
    wait_cyc(tc + 17);
    chk("midreset idx_before", idx[0], 5);
    rst = 1'b1;
    q[0].delete();
    @(negedge clk);
    chk("midreset busy", busy[0], 0);
    chk("midreset key", rk[0], 0);
    chk("midreset valid", vld[0], 0);
    chk("midreset idx", idx[0], 0);
    chk("midreset done", done[0], 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("midreset stays_idle", busy[0], 0);
    kick(0, tbl[0].key, tc);
    push_run(0, 0, tc, 2);
    wait_cyc(tc + 32);
    chk("midreset rerun_drained", q[0].size(), 0);
    repeat (2) @(negedge clk);

    // Start pulse with another key during round 3.
    kick(0, tbl[0].key, tc);
    push_run(0, 0, tc, 2);
    wait_cyc(tc + 10);
    kick(0, tbl[1].key, tc2);
`ifdef AES_KEY_EXP_RESTART_EN
    q[0].delete();
    push_run(0, 1, tc2, 2);
    wait_cyc(tc2 + 31);
    chk("restart round10", rk[0], tbl[1].rk[10]);
    wait_cyc(tc2 + 32);
`else
    wait_cyc(tc + 32);
    chk("ignored_start round10", rk[0], tbl[0].rk[10]);
`endif
    chk("midstart drained", q[0].size(), 0);
    repeat (2) @(negedge clk);

    // Output-registered S-box variant: 4-cycle spacing, round 10 at T+41.
    kick(1, tbl[0].key, tc);
    push_run(1, 0, tc, 3);
    wait_cyc(tc + 41);
    chk("oreg round10_key", rk[1], tbl[0].rk[10]);
    chk("oreg round10_idx", idx[1], 10);
    chk("oreg busy_round10", busy[1], 1);
    wait_cyc(tc + 42);
    chk("oreg busy_after", busy[1], 0);
    chk("oreg drained", q[1].size(), 0);
    repeat (2) @(negedge clk);

    // Back-to-back runs: second start lands one cycle after round 10.
    nd = ndone[0];
    key[0]   = tbl[0].key;
    start[0] = 1'b1;
    @(negedge clk);
    tc = cyc;
    push_run(0, 0, tc, 2);
    push_run(0, 0, tc + 32, 2);
`ifdef AES_KEY_EXP_RESTART_EN
    start[0] = 1'b0;
    wait_cyc(tc + 31);
    start[0] = 1'b1;
`endif
    wait_cyc(tc + 32);
    start[0] = 1'b0;
    wait_cyc(tc + 32 + 33);
    chk("b2b drained", q[0].size(), 0);
    chk("b2b done_count", ndone[0] - nd, 2);
    chk("b2b busy_after", busy[0], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
